// File: rtl/interlacer.sv
// Progressive-to-interlaced converter for Avalon-ST video.
// Each input video packet becomes a fresh control packet plus one half-height field;
// the field parity (even lines / odd lines) alternates from frame to frame.
module interlacer #(
    parameter int unsigned BITS_PER_SYMBOL = 8,
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned WIDTH           = 640,
    parameter int unsigned HEIGHT          = 480
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] din_data,
    input  logic                  din_valid,
    output logic                  din_ready,
    input  logic                  din_startofpacket,
    input  logic                  din_endofpacket,
    output logic [DATA_WIDTH-1:0] dout_data,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  dout_startofpacket,
    output logic                  dout_endofpacket
);

    localparam int unsigned ColW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned RowW = $clog2(HEIGHT);

    localparam logic [ColW-1:0] ColLast     = ColW'(WIDTH - 1);
    localparam logic [RowW-1:0] RowLast     = RowW'(HEIGHT - 1);
    localparam logic [RowW-1:0] RowLastEven = RowW'(HEIGHT - 2);
    localparam logic [15:0]     Width16     = 16'(WIDTH);
    localparam logic [15:0]     Half16      = 16'(HEIGHT / 2);

    if (DATA_WIDTH < 8 || BITS_PER_SYMBOL == 0 || HEIGHT < 2 || (HEIGHT % 2) != 0)
    begin : g_param_check
        $error("interlacer: unsupported parameter set");
    end

    typedef enum logic [2:0] {
        StIdle,
        StDiscard,
        StSendCtrl,
        StSendHdr,
        StLines,
        StFlush
    } state_e;

    state_e          state_q, state_d;
    logic [ColW-1:0] col_q, col_d;
    logic [RowW-1:0] row_q, row_d;
    logic            field_odd_q, field_odd_d;
    logic            eop_sent_q, eop_sent_d;
    logic [3:0]      ctrl_cnt_q, ctrl_cnt_d;

    logic                  load;
    logic                  rdy;
    logic                  emit;
    logic [DATA_WIDTH-1:0] emit_data;
    logic                  emit_sop;
    logic                  emit_eop;
    logic [3:0]            ctrl_nib;
    logic                  keep;
    logic                  last_col;
    logic                  frame_last;
    logic                  last_kept;

    // Output stage may take a new beat when empty or being drained this cycle.
    assign load       = !dout_valid || dout_ready;
    assign keep       = (row_q[0] == field_odd_q);
    assign last_col   = (col_q == ColLast);
    assign frame_last = last_col && (row_q == RowLast);
    assign last_kept  = last_col && (row_q == (field_odd_q ? RowLast : RowLastEven));

    // Held low during reset so nothing is accepted before the state machine is live.
    assign din_ready = rdy && !reset;

    // Control packet content, one nibble per beat.
    always_comb begin
        ctrl_nib = 4'h0;
        case (ctrl_cnt_q)
            4'd0:    ctrl_nib = 4'hF;
            4'd1:    ctrl_nib = Width16[15:12];
            4'd2:    ctrl_nib = Width16[11:8];
            4'd3:    ctrl_nib = Width16[7:4];
            4'd4:    ctrl_nib = Width16[3:0];
            4'd5:    ctrl_nib = Half16[15:12];
            4'd6:    ctrl_nib = Half16[11:8];
            4'd7:    ctrl_nib = Half16[7:4];
            4'd8:    ctrl_nib = Half16[3:0];
            4'd9:    ctrl_nib = field_odd_q ? 4'hC : 4'h8;
            default: ctrl_nib = 4'h0;
        endcase
    end

    // Next-state logic, sink ready and the beat offered to the output stage.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        field_odd_d = field_odd_q;
        eop_sent_d  = eop_sent_q;
        ctrl_cnt_d  = ctrl_cnt_q;
        rdy         = 1'b0;
        emit        = 1'b0;
        emit_data   = '0;
        emit_sop    = 1'b0;
        emit_eop    = 1'b0;

        case (state_q)
            StIdle: begin
                rdy = 1'b1;
                if (din_valid && din_startofpacket) begin
                    if (din_data[3:0] == 4'h0) begin
                        state_d    = StSendCtrl;
                        ctrl_cnt_d = 4'd0;
                    end else if (!din_endofpacket) begin
                        state_d = StDiscard;
                    end
                end
            end

            StDiscard: begin
                rdy = 1'b1;
                if (din_valid && din_endofpacket) begin
                    state_d = StIdle;
                end
            end

            StSendCtrl: begin
                if (load) begin
                    emit       = 1'b1;
                    emit_data  = DATA_WIDTH'(ctrl_nib);
                    emit_sop   = (ctrl_cnt_q == 4'd0);
                    emit_eop   = (ctrl_cnt_q == 4'd9);
                    ctrl_cnt_d = ctrl_cnt_q + 4'd1;
                    if (ctrl_cnt_q == 4'd9) begin
                        state_d = StSendHdr;
                    end
                end
            end

            StSendHdr: begin
                if (load) begin
                    emit       = 1'b1;
                    emit_sop   = 1'b1;
                    state_d    = StLines;
                    col_d      = '0;
                    row_d      = '0;
                    eop_sent_d = 1'b0;
                end
            end

            StLines: begin
                // Dropped lines never wait on the output stage.
                rdy = keep ? load : 1'b1;
                if (din_valid && rdy) begin
                    if (keep) begin
                        emit      = 1'b1;
                        emit_data = din_data;
                        emit_eop  = last_kept || (din_endofpacket && !eop_sent_q);
                        if (emit_eop) begin
                            eop_sent_d = 1'b1;
                        end
                    end
                    if (last_col) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                    if (din_endofpacket) begin
                        field_odd_d = !field_odd_q;
                        // Short packet ending on a dropped line still needs a closing eop.
                        state_d     = (!keep && !eop_sent_q) ? StFlush : StIdle;
                    end else if (frame_last) begin
                        field_odd_d = !field_odd_q;
                        state_d     = StDiscard;
                    end
                end
            end

            StFlush: begin
                if (load) begin
                    emit     = 1'b1;
                    emit_eop = 1'b1;
                    state_d  = StIdle;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            col_q       <= '0;
            row_q       <= '0;
            field_odd_q <= 1'b0;
            eop_sent_q  <= 1'b0;
            ctrl_cnt_q  <= 4'd0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            field_odd_q <= field_odd_d;
            eop_sent_q  <= eop_sent_d;
            ctrl_cnt_q  <= ctrl_cnt_d;
        end
    end

    // Output stage: reloads whenever free, otherwise holds every field stable.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dout_valid         <= 1'b0;
            dout_data          <= '0;
            dout_startofpacket <= 1'b0;
            dout_endofpacket   <= 1'b0;
        end else if (load) begin
            dout_valid         <= emit;
            dout_data          <= emit_data;
            dout_startofpacket <= emit_sop;
            dout_endofpacket   <= emit_eop;
        end
    end

endmodule

// File: tb/tb_interlacer.sv
// Scoreboard bench for interlacer on a 4x4 frame.
module tb_interlacer;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int DW = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] din_data = '0;
    logic          din_valid = 1'b0;
    logic          din_ready;
    logic          din_startofpacket = 1'b0;
    logic          din_endofpacket = 1'b0;
    logic [DW-1:0] dout_data;
    logic          dout_valid;
    logic          dout_ready = 1'b1;
    logic          dout_startofpacket;
    logic          dout_endofpacket;

    int         checks = 0;
    int         errors = 0;
    logic [9:0] sb_q[$];
    bit         exp_field = 1'b0;
    bit         rand_ready = 1'b0;

    always #5 clock = ~clock;

    interlacer #(
        .BITS_PER_SYMBOL(8),
        .DATA_WIDTH     (DW),
        .WIDTH          (W),
        .HEIGHT         (H)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .din_data          (din_data),
        .din_valid         (din_valid),
        .din_ready         (din_ready),
        .din_startofpacket (din_startofpacket),
        .din_endofpacket   (din_endofpacket),
        .dout_data         (dout_data),
        .dout_valid        (dout_valid),
        .dout_ready        (dout_ready),
        .dout_startofpacket(dout_startofpacket),
        .dout_endofpacket  (dout_endofpacket)
    );

    task automatic check_eq(input string tag, input logic [31:0] actual,
                            input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    // Downstream ready: solid or coin-flip, changed on the falling edge.
    initial begin
        forever begin
            @(negedge clock);
            dout_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor: {sop, eop, data} against the scoreboard head.
    initial begin
        forever begin
            @(negedge clock);
            #2;
            if (!reset && dout_valid) begin
                if (sb_q.size() == 0) begin
                    check_eq("sb_underflow", sb_q.size(), 1);
                end else if (dout_ready) begin
                    check_eq("beat", {dout_startofpacket, dout_endofpacket, dout_data},
                             sb_q.pop_front());
                end else begin
                    check_eq("stall_hold", {dout_startofpacket, dout_endofpacket, dout_data},
                             sb_q[0]);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // Called on a falling edge; returns on the falling edge after the beat transfers.
    task automatic drive(input logic [7:0] data, input bit sop, input bit eop, output int waits);
        bit rdy;
        bit done;
        din_data          = data;
        din_startofpacket = sop;
        din_endofpacket   = eop;
        din_valid         = 1'b1;
        waits             = 0;
        done              = 1'b0;
        while (!done) begin
            #1;
            rdy = din_ready;
            @(posedge clock);
            @(negedge clock);
            if (rdy) begin
                done = 1'b1;
            end else begin
                waits++;
                if (waits > 200) begin
                    check_eq("din_timeout", waits, 0);
                    done = 1'b1;
                end
            end
        end
    endtask

    task automatic push_ctrl();
        logic [15:0] w16;
        logic [15:0] h16;
        w16 = 16'(W);
        h16 = 16'(H / 2);
        sb_q.push_back({2'b10, 8'h0F});
        for (int s = 12; s >= 0; s -= 4) sb_q.push_back({2'b00, 4'h0, 4'((w16 >> s) & 16'hF)});
        for (int s = 12; s >= 0; s -= 4) sb_q.push_back({2'b00, 4'h0, 4'((h16 >> s) & 16'hF)});
        sb_q.push_back({2'b01, exp_field ? 8'h0C : 8'h08});
        sb_q.push_back({2'b10, 8'h00});
    endtask

    task automatic send_other(input logic [7:0] typ);
        int waits;
        drive(typ, 1'b1, 1'b0, waits);
        drive(8'h00, 1'b0, 1'b0, waits);
        drive(8'h04, 1'b0, 1'b0, waits);
        drive(8'h01, 1'b0, 1'b1, waits);
        din_valid = 1'b0;
    endtask

    // Video packet of npix pixels valued 0,1,2..; model predicts the field output.
    task automatic send_video(input int npix);
        int waits;
        bit in_lines;
        bit eop_sent;
        bit last;
        bit keep;
        bit lk;
        bit eop_o;
        bit was_drain;
        int row;
        int col;
        in_lines = 1'b1;
        eop_sent = 1'b0;
        push_ctrl();
        drive(8'h00, 1'b1, 1'b0, waits);
        for (int i = 0; i < npix; i++) begin
            last = (i == npix - 1);
            row  = i / W;
            col  = i % W;
            keep = 1'b0;
            was_drain = !in_lines;
            if (in_lines) begin
                keep  = ((row % 2) == int'(exp_field));
                lk    = (col == W - 1) && (row == (exp_field ? H - 1 : H - 2));
                if (keep) begin
                    eop_o = lk || (last && !eop_sent);
                    if (eop_o) eop_sent = 1'b1;
                    sb_q.push_back({1'b0, eop_o, 8'(i)});
                end else if (last && !eop_sent) begin
                    sb_q.push_back({2'b01, 8'h00});
                end
                if (last || i == W * H - 1) begin
                    in_lines  = 1'b0;
                    exp_field = !exp_field;
                end
            end
            drive(8'(i), 1'b0, last, waits);
            if (was_drain) check_eq("drain_ready", waits, 0);
            else if (!keep && i > 0) check_eq("drop_ready", waits, 0);
        end
        din_valid       = 1'b0;
        din_endofpacket = 1'b0;
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 400) begin
            @(negedge clock);
            n++;
        end
        repeat (2) @(negedge clock);
        check_eq("sb_empty", sb_q.size(), 0);
    endtask

    initial begin
        int waits;
        // Reset state
        repeat (2) @(negedge clock);
        check_eq("rst_valid", dout_valid, 0);
        check_eq("rst_data", dout_data, 0);
        check_eq("rst_sop", dout_startofpacket, 0);
        check_eq("rst_eop", dout_endofpacket, 0);
        check_eq("rst_din_ready", din_ready, 0);
        reset = 1'b0;
        #1;
        check_eq("idle_din_ready", din_ready, 1);
        @(negedge clock);

        // F0, F1, F0 with solid ready
        for (int f = 0; f < 3; f++) begin
            send_other(8'h0F);
            send_video(W * H);
            wait_empty();
        end

        // Random backpressure across three frames
        rand_ready = 1'b1;
        for (int f = 0; f < 3; f++) begin
            send_other(8'h0F);
            send_video(W * H);
            wait_empty();
        end
        rand_ready = 1'b0;
        @(negedge clock);

        // Truncated F0 after pixel 5, then a full F1
        send_video(6);
        wait_empty();
        send_video(W * H);
        wait_empty();

        // Oversized F0 packet, then a user packet that must vanish
        send_video(20);
        wait_empty();
        send_other(8'h05);
        wait_empty();

        // Reset in the middle of the kept line of an F1 frame
        push_ctrl();
        drive(8'h00, 1'b1, 1'b0, waits);
        for (int i = 0; i < 6; i++) begin
            if (i >= 4) sb_q.push_back({2'b00, 8'(i)});
            drive(8'(i), 1'b0, 1'b0, waits);
        end
        din_valid = 1'b0;
        #3;
        check_eq("pre_rst_valid", dout_valid, 1);
        check_eq("pre_rst_sb", sb_q.size(), 0);
        reset = 1'b1;
        #1;
        check_eq("mid_rst_valid", dout_valid, 0);
        check_eq("mid_rst_din_ready", din_ready, 0);
        sb_q.delete();
        exp_field = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        send_other(8'h0F);
        send_video(W * H);
        wait_empty();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/interlacer.md
# interlacer

Converts progressive Avalon-ST video frames into alternating interlaced fields: F0 carries the even lines, F1 the odd lines, and parity toggles every frame. It is the inverse of the team's deinterlacer. It sits between a progressive source and any field-based consumer. For each input video packet it regenerates its own control packet and emits one half-height field, discarding the lines of the opposite parity.

## Interface
- BITS_PER_SYMBOL, 8, bits per pixel symbol
- DATA_WIDTH, 8, din/dout data width; must be ≥ 8
- WIDTH, 640, pixels per line
- HEIGHT, 480, lines per progressive frame; must be even
- clock  in  1  single clock; all logic on its rising edge
- reset  in  1  asynchronous, active-high reset
- din_data  in  DATA_WIDTH  sink pixel or packet-type beat
- din_valid  in  1  sink beat valid
- din_ready  out  1  sink may accept; transfer when din_valid && din_ready
- din_startofpacket  in  1  first beat of packet (type nibble in data[3:0])
- din_endofpacket  in  1  last beat of packet
- dout_data  out  DATA_WIDTH  source beat
- dout_valid  out  1  source beat valid
- dout_ready  in  1  downstream accepts; transfer when dout_valid && dout_ready (ready latency 0)
- dout_startofpacket  out  1  first beat of output packet
- dout_endofpacket  out  1  last beat of output packet

## Operation
- Output stage is a single register set (data/valid/sop/eop). It loads when `!dout_valid || dout_ready`; otherwise it holds all values stable.
- din_ready is combinational from state and output-stage availability.
- field_odd register: 0 = F0 (keep even lines), 1 = F1 (keep odd lines). Reset value 0. Toggles after every video packet ends, whether complete or truncated.
- States:
  - IDLE: din_ready=1. On a sop beat with data[3:0]=0xF, go to DISCARD. On 0x0, go to SEND_CTRL. On any other type, go to DISCARD. Non-sop beats are dropped.
  - DISCARD: din_ready=1. Consume beats until din_endofpacket, then go to IDLE. Nothing is output.
  - SEND_CTRL: din_ready=0. Emit 10 beats: 0x0F with sop; then nibbles W[15:12], W[11:8], W[7:4], W[3:0], H2[15:12], H2[11:8], H2[7:4], H2[3:0], with H2=HEIGHT/2; then the interlace nibble, 0x8 for F0 or 0xC for F1, with eop. Each nibble is zero-extended. Go to SEND_HDR.
  - SEND_HDR: din_ready=0. Emit 0x00 with sop, then go to LINES with col=0 and row=0.
  - LINES: each accepted din beat advances col, wrapping at WIDTH-1, with row incremented on wrap. If row[0]==field_odd the beat is kept: din_ready = output stage free, and the pixel goes to dout. Otherwise the beat is dropped: din_ready=1 and nothing is output.
  - End of field: dout_endofpacket is set on the last kept pixel. For F0 that is row HEIGHT-2, col WIDTH-1. For F1 it is row HEIGHT-1, col WIDTH-1.
  - Leaving LINES: if din_endofpacket arrives on the frame's final beat, go to IDLE. Otherwise go to DISCARD and drain the extra input beats.
- Early din_endofpacket before the frame completes:
  - If the output eop has not been sent and the beat is kept, it carries dout_endofpacket.
  - If the beat is dropped, emit one flush beat, data 0 with eop, then go to IDLE.
  - field_odd toggles in both cases.
- Counters: col is $clog2(WIDTH) bits, row is $clog2(HEIGHT) bits. Both compare against WIDTH-1 and HEIGHT-1; there is no implicit wrap.

## Timing
- Reset values: dout_valid=0, dout_data=0, dout_startofpacket=0, dout_endofpacket=0, din_ready=0 (asserted combinationally from IDLE after reset deasserts), state=IDLE, col=0, row=0, field_odd=0.
- Reset mid-operation abandons the frame: outputs go to 0 immediately and field_odd returns to 0.
- Kept pixel latency: 1 cycle from the din transfer to dout_valid.
- Throughput: with dout_ready held at 1, one beat per cycle and no bubbles on kept lines. Dropped lines consume one beat per cycle with no output.
- Control and header generation: 11 output beats, minimum 11 cycles. din_ready=0 throughout, so the video type beat is accepted and input stalls until SEND_HDR completes.
- Backpressure: while dout_valid=1 and dout_ready=0, dout_* stays stable and din_ready=0 in the kept phase.
- Simultaneous load and drain of the output register in the same cycle is required; it must not cost a bubble.

## Test plan
- WIDTH=4, HEIGHT=4, ctrl packet then video packet of pixels 0..15, dout_ready=1 → 10-beat ctrl (0F,0,0,0,4,0,0,0,2,8), header 00 with sop, pixels 0,1,2,3,8,9,10,11 with eop on 11. Input is fully consumed.
- Second identical frame → interlace nibble 0xC, output pixels 4,5,6,7,12,13,14,15 with eop on 15. Third frame returns to F0.
- Random dout_ready with 50% duty → same output sequence as above, dout_* stable while stalled, no pixel lost or duplicated.
- Video packet truncated after pixel 5 (eop, row 1 during F0) → output 0,1,2,3 then flush beat 00 with eop. The next frame is F1.
- Oversized packet with 20 pixels in a 4x4 frame → eop on the last kept pixel, 4 trailing beats absorbed, din_ready=1 until din eop.
- Reset asserted mid-line → dout_valid drops to 0 asynchronously. The next frame starts with F0 and a full control packet.
